// File: rtl/hpi_responder.sv
// Target side of the 4-register HPI bus: address pointer, auto-incrementing data
// window into a local word RAM, bidirectional mailboxes, status and keycode shadow.
module hpi_responder #(
    parameter int          MEM_AW   = 10,
    parameter logic [15:0] KEY_ADDR = 16'h051C
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  hpi_address,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic        hpi_reset_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_int,
    input  logic [15:0] dev_mbx_wdata,
    input  logic        dev_mbx_we,
    output logic [15:0] dev_mbx_rdata,
    output logic        dev_mbx_valid,
    input  logic        dev_mbx_ack,
    output logic [15:0] keycode
);

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_MAILBOX = 2'd1,
        REG_ADDRESS = 2'd2,
        REG_STATUS  = 2'd3
    } hpi_reg_e;

    localparam int MEM_WORDS = 1 << MEM_AW;

    // Two-stage copy of the bus pins; s1 is the synchronised view, s2 its delayed twin
    hpi_reg_e    addr_s1, addr_s2;
    logic        cs_n_s1, cs_n_s2;
    logic        r_n_s1, r_n_s2;
    logic        w_n_s1, w_n_s2;
    logic        host_rst_n_s1;
    logic [15:0] data_s1, data_s2;

    logic [15:0] ptr_reg, ptr_next;
    logic [15:0] mbx_out_reg, mbx_in_reg;
    logic        out_full_reg, in_full_reg;
    logic [15:0] keycode_reg;
    logic [15:0] data_out_reg;

    logic [15:0] ram [MEM_WORDS];
    logic [15:0] ram_rd_reg;
    logic [MEM_AW-1:0] ram_wr_idx, ram_rd_idx;
    logic        ram_we;

    logic        soft_rst, write_commit, read_done, read_active;
    logic [15:0] read_value;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_s1       <= REG_DATA;
            addr_s2       <= REG_DATA;
            cs_n_s1       <= 1'b1;
            cs_n_s2       <= 1'b1;
            r_n_s1        <= 1'b1;
            r_n_s2        <= 1'b1;
            w_n_s1        <= 1'b1;
            w_n_s2        <= 1'b1;
            host_rst_n_s1 <= 1'b1;
            data_s1       <= 16'h0000;
            data_s2       <= 16'h0000;
        end else begin
            addr_s1       <= hpi_reg_e'(hpi_address);
            addr_s2       <= addr_s1;
            cs_n_s1       <= hpi_cs_n;
            cs_n_s2       <= cs_n_s1;
            r_n_s1        <= hpi_r_n;
            r_n_s2        <= r_n_s1;
            w_n_s1        <= hpi_w_n;
            w_n_s2        <= w_n_s1;
            host_rst_n_s1 <= hpi_reset_n;
            data_s1       <= hpi_data_in;
            data_s2       <= data_s1;
        end
    end

    // A strobe ending while the other strobe was also low is treated as a non-access;
    // a chip select that went high before the strobe leaves s2 cs_n high and kills the commit.
    assign soft_rst     = !host_rst_n_s1;
    assign write_commit = !w_n_s2 && w_n_s1 && !cs_n_s2 && r_n_s2;
    assign read_done    = !r_n_s2 && r_n_s1 && !cs_n_s2 && w_n_s2;
    assign read_active  = !cs_n_s1 && !r_n_s1 && w_n_s1;

    always_comb begin
        ptr_next = ptr_reg;
        if (soft_rst) begin
            ptr_next = 16'h0000;
        end else if (write_commit) begin
            case (addr_s2)
                REG_DATA:    ptr_next = ptr_reg + 16'd2;
                REG_ADDRESS: ptr_next = data_s2 & 16'hFFFE;
                default:     ptr_next = ptr_reg;
            endcase
        end else if (read_done && addr_s2 == REG_DATA) begin
            ptr_next = ptr_reg + 16'd2;
        end
    end

    assign ram_we     = !soft_rst && write_commit && addr_s2 == REG_DATA;
    assign ram_wr_idx = ptr_reg[MEM_AW:1];
    assign ram_rd_idx = ptr_next[MEM_AW:1];

    // The read port follows ptr_next so ram_rd_reg already holds the word under the
    // pointer when a read starts. A data write always moves the pointer off the
    // written word, so read-before-write ordering never returns stale data.
    always_ff @(posedge clk_clk) begin
        if (ram_we) begin
            ram[ram_wr_idx] <= data_s2;
        end
        ram_rd_reg <= ram[ram_rd_idx];
    end

    always_comb begin
        read_value = 16'h0000;
        case (addr_s1)
            REG_DATA:    read_value = ram_rd_reg;
            REG_MAILBOX: read_value = mbx_out_reg;
            REG_ADDRESS: read_value = ptr_reg;
            REG_STATUS:  read_value = {14'b0, in_full_reg, out_full_reg};
            default:     read_value = 16'h0000;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ptr_reg      <= 16'h0000;
            mbx_out_reg  <= 16'h0000;
            out_full_reg <= 1'b0;
            mbx_in_reg   <= 16'h0000;
            in_full_reg  <= 1'b0;
            keycode_reg  <= 16'h0000;
            data_out_reg <= 16'h0000;
        end else begin
            ptr_reg <= ptr_next;
            if (soft_rst) begin
                mbx_out_reg  <= 16'h0000;
                out_full_reg <= 1'b0;
                mbx_in_reg   <= 16'h0000;
                in_full_reg  <= 1'b0;
                data_out_reg <= 16'h0000;
            end else begin
                // Later assignments win: host write beats ack, device load beats host read
                if (dev_mbx_ack) begin
                    in_full_reg <= 1'b0;
                end
                if (write_commit) begin
                    case (addr_s2)
                        REG_DATA: begin
                            if (ptr_reg == KEY_ADDR) begin
                                keycode_reg <= data_s2;
                            end
                        end
                        REG_MAILBOX: begin
                            mbx_in_reg  <= data_s2;
                            in_full_reg <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (read_done && addr_s2 == REG_MAILBOX) begin
                    out_full_reg <= 1'b0;
                end
                if (dev_mbx_we) begin
                    mbx_out_reg  <= dev_mbx_wdata;
                    out_full_reg <= 1'b1;
                end
                if (read_active) begin
                    data_out_reg <= read_value;
                end
            end
        end
    end

    assign hpi_data_out  = data_out_reg;
    assign hpi_int       = out_full_reg;
    assign dev_mbx_rdata = mbx_in_reg;
    assign dev_mbx_valid = in_full_reg;
    assign keycode       = keycode_reg;

endmodule
